// File: rtl/nw_score_sequencer.sv
// Needleman-Wunsch score sequencer: boundary init, row-major cell fill, then done.
// Registered outputs; READ and CALC stall without limit on ready / calc_done (4 cycles per cell when both answer at once).
module nw_score_sequencer #(
  parameter int N       = 5,
  parameter int BitAddr = $clog2(N),
  parameter int GAP_PEN = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ready,
  input  logic             calc_done,
  input  logic [8:0]       calc_max,
  output logic             en_init,
  output logic             en_read,
  output logic             en_ins,
  output logic             we,
  output logic [BitAddr:0] addr_init,
  output logic [8:0]       data_init,
  output logic [BitAddr:0] i,
  output logic [BitAddr:0] j,
  output logic [8:0]       max,
  output logic             calc_start,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    READ,
    CALC,
    WRITE,
    NEXT,
    DONE
  } state_t;

  localparam logic [BitAddr:0] K_LAST   = (BitAddr + 1)'(N);
  localparam logic [BitAddr:0] IDX_LAST = (BitAddr + 1)'(N - 1);
  localparam logic [8:0]       GAP9     = 9'(GAP_PEN);

  state_t state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      en_init    <= 1'b0;
      en_read    <= 1'b0;
      en_ins     <= 1'b0;
      we         <= 1'b0;
      addr_init  <= '0;
      data_init  <= '0;
      i          <= '0;
      j          <= '0;
      max        <= '0;
      calc_start <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      calc_start <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= INIT;
            en_init   <= 1'b1;
            we        <= 1'b1;
            addr_init <= '0;
            data_init <= '0;
            i         <= '0;
            j         <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
          end
        end
        // addr_init doubles as the boundary index; data_init tracks -(k*GAP) mod 512
        INIT: begin
          if (addr_init == K_LAST) begin
            state   <= READ;
            en_init <= 1'b0;
            we      <= 1'b0;
            en_read <= 1'b1;
          end else begin
            addr_init <= addr_init + 1'b1;
            data_init <= data_init - GAP9;
          end
        end
        READ: begin
          if (ready) begin
            state      <= CALC;
            calc_start <= 1'b1;
          end
        end
        CALC: begin
          if (calc_done) begin
            state   <= WRITE;
            max     <= calc_max;
            en_read <= 1'b0;
            en_ins  <= 1'b1;
            we      <= 1'b1;
          end
        end
        WRITE: begin
          state  <= NEXT;
          en_ins <= 1'b0;
          we     <= 1'b0;
        end
        NEXT: begin
          if (j < IDX_LAST) begin
            j       <= j + 1'b1;
            state   <= READ;
            en_read <= 1'b1;
          end else if (i < IDX_LAST) begin
            j       <= '0;
            i       <= i + 1'b1;
            state   <= READ;
            en_read <= 1'b1;
          end else begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nw_score_sequencer.sv
// Directed bench for nw_score_sequencer with a row-major write scoreboard and a reactive
// ready/calc_done responder that can stall, delay and inject stray handshakes.
module tb_nw_score_sequencer;

  localparam int N   = 5;
  localparam int GAP = 2;
  localparam int BA  = $clog2(N);

  logic          clk        = 1'b0;
  logic          rst        = 1'b1;
  logic          start      = 1'b0;
  logic          ready      = 1'b1;
  logic          calc_done  = 1'b0;
  logic [8:0]    calc_max   = 9'h000;
  logic          en_init, en_read, en_ins, we, calc_start, busy, done;
  logic [BA:0]   addr_init, i, j;
  logic [8:0]    data_init, max;

  int n_cmp  = 0;
  int n_fail = 0;
  int vals [N*N];
  bit stall_en = 1'b0;
  bit spur_en  = 1'b0;

  always #5 clk = ~clk;

  nw_score_sequencer #(.N(N), .GAP_PEN(GAP)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .ready      (ready),
    .calc_done  (calc_done),
    .calc_max   (calc_max),
    .en_init    (en_init),
    .en_read    (en_read),
    .en_ins     (en_ins),
    .we         (we),
    .addr_init  (addr_init),
    .data_init  (data_init),
    .i          (i),
    .j          (j),
    .max        (max),
    .calc_start (calc_start),
    .busy       (busy),
    .done       (done)
  );

  // Responder: the score manager's ready and the max unit's calc_done/calc_max
  int rcnt       = 0;
  int stall_left = 0;
  int wait_left  = 0;
  int cur        = 0;

  always @(negedge clk) begin
    calc_done = 1'b0;
    calc_max  = 9'h000;
    ready     = 1'b1;
    if (en_init) begin
      rcnt       = 0;
      stall_left = 5;
      wait_left  = 0;
    end
    if (stall_en && rcnt == 6 && stall_left > 0 && en_read) begin
      ready = 1'b0;
      if (stall_left == 3) begin
        calc_done = 1'b1;
        calc_max  = 9'h1AA;
      end
      stall_left--;
    end
    if (spur_en && busy && !en_init && !en_read && !en_ins && rcnt == 10) begin
      calc_done = 1'b1;
      calc_max  = 9'h155;
    end
    if (calc_start) begin
      cur = rcnt;
      rcnt++;
      if (stall_en && cur == 6) begin
        wait_left = 3;
      end else begin
        calc_done = 1'b1;
        calc_max  = (cur < N*N) ? 9'(vals[cur]) : 9'h000;
      end
    end else if (wait_left > 0) begin
      wait_left--;
      if (wait_left == 0) begin
        calc_done = 1'b1;
        calc_max  = 9'(vals[cur]);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle model state: boundary index, row-major cell index, calc_start count
  bit          p_init, p_rd, p_cs, p_done;
  logic [BA:0] p_i, p_j;
  int          ii, ci, cs_n;

  task automatic compare_cycle();
    if (!rst) begin
      p_init = 0; p_rd = 0; p_cs = 0; p_done = 0;
      ii = 0; ci = 0; cs_n = 0;
      return;
    end
    chk("en_exclusive", int'((int'(en_init) + int'(en_read) + int'(en_ins)) <= 1), 1);
    chk("we_vs_en", int'(we), int'(en_init | en_ins));
    chk("busy_done_excl", int'(busy && done), 0);
    chk("en_needs_busy", int'(!busy && (en_init || en_read || en_ins || calc_start)), 0);
    if (en_init && !p_init) begin
      ii = 0; ci = 0; cs_n = 0;
    end
    if (en_init) begin
      chk("init_addr", int'(addr_init), ii);
      chk("init_data", int'(data_init), (512 - ii * GAP) % 512);
      chk("init_before_fill", ci, 0);
      ii++;
    end
    if (calc_start) begin
      chk("cs_with_read", int'(en_read), 1);
      chk("cs_single", int'(p_cs), 0);
      cs_n++;
    end
    if (en_read && p_rd) begin
      chk("read_i_stable", int'(i), int'(p_i));
      chk("read_j_stable", int'(j), int'(p_j));
    end
    if (en_ins) begin
      chk("ins_after_init", ii, N + 1);
      chk("ins_i", int'(i), ci / N);
      chk("ins_j", int'(j), ci % N);
      chk("ins_max", int'(max), (ci < N*N) ? vals[ci] : -1);
      ci++;
    end
    if (done && !p_done) begin
      chk("done_cells", ci, N * N);
      chk("done_calc_starts", cs_n, N * N);
    end
    p_init = en_init; p_rd = en_read; p_cs = calc_start; p_done = done;
    p_i = i; p_j = j;
  endtask

  task automatic run_full(input string tag, input int exp_cyc, input bit mid_start);
    int cyc;
    int lit [6];
    lit = '{0, 510, 508, 506, 504, 502};
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_done_cleared"}, int'(done), 0);
    cyc = 0;
    while (!done && cyc < 2000) begin
      if (cyc < 6) begin
        chk({tag, "_lit_en_init"}, int'(en_init), 1);
        chk({tag, "_lit_addr"}, int'(addr_init), cyc);
        chk({tag, "_lit_data"}, int'(data_init), lit[cyc]);
      end
      @(negedge clk);
      cyc++;
      start = mid_start && (cyc == 50 || cyc == 51);
    end
    start = 1'b0;
    chk({tag, "_done_cycle"}, cyc, exp_cyc);
    chk({tag, "_final_i"}, int'(i), 4);
    chk({tag, "_final_j"}, int'(j), 4);
    chk({tag, "_final_max"}, int'(max), 27);
  endtask

  initial begin
    int cyc;
    for (int k = 0; k < N*N; k++) vals[k] = 7 + 4 * (k / N) + (k % N);

    #1 rst = 1'b0;
    #1;
    chk("rst_en_init", int'(en_init), 0);
    chk("rst_en_read", int'(en_read), 0);
    chk("rst_en_ins", int'(en_ins), 0);
    chk("rst_we", int'(we), 0);
    chk("rst_calc_start", int'(calc_start), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ij", int'({i, j}), 0);
    chk("rst_addr", int'(addr_init), 0);
    chk("rst_data", int'(data_init), 0);
    chk("rst_max", int'(max), 0);

    fork
      forever begin
        @(negedge clk);
        compare_cycle();
      end
    join_none

    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("idle_busy", int'(busy), 0);
      chk("idle_done", int'(done), 0);
      chk("idle_en", int'(en_init | en_read | en_ins | we), 0);
    end

    run_full("zw", 106, 1'b0);

    vals[6] = 14;
    stall_en = 1'b1;
    spur_en  = 1'b1;
    repeat (3) @(negedge clk);
    chk("done_held", int'(done), 1);
    run_full("stall", 114, 1'b1);
    vals[6]  = 12;
    stall_en = 1'b0;
    spur_en  = 1'b0;

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(en_ins && i == 2 && j == 3) && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    chk("reach_write_2_3", int'(en_ins && i == 2 && j == 3), 1);
    #2 rst = 1'b0;
    #1;
    chk("abort_en_ins", int'(en_ins), 0);
    chk("abort_we", int'(we), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_ij", int'({i, j}), 0);
    chk("abort_max", int'(max), 0);
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("post_abort_idle", int'(busy | en_init | en_read | en_ins | done), 0);
    end

    run_full("rerun", 106, 1'b0);
    run_full("redone", 106, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/nw_score_sequencer.md
Name: nw_score_sequencer

Overview:
- Top-level sequencer for the Needleman-Wunsch score-matrix RAM manager.
- After `start`, it runs three phases in order:
  - Boundary init: writes the gap-penalty values of row 0 and column 0.
  - Cell fill: walks every inner cell (i,j) in row-major order. For each cell it reads diag/up/left, hands them to the external max/compare unit, waits for the result, then inserts that result.
  - Done: holds `done` high until the next `start`.
- It owns all enable/address/data control inputs of the score manager.

Parameters:
- N, 5, sequence length; the matrix is (N+1)x(N+1).
- BitAddr, $clog2(N), index MSB; i, j and addr_init are [BitAddr:0].
- GAP_PEN, 2, unsigned gap penalty per step; boundary value = -(k*GAP_PEN), 9-bit two's complement.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin a full matrix run; sampled only in IDLE or DONE.
- ready  in  1  score manager: diag/up/left valid for the current (i,j).
- calc_done  in  1  max unit: calc_max valid, single-cycle pulse.
- calc_max  in  9  max unit result for the current cell.
- en_init  out  1  boundary-init write phase to the score manager.
- en_read  out  1  neighbour-read request to the score manager.
- en_ins  out  1  cell-insert request to the score manager.
- we  out  1  RAM write enable; high with en_init or en_ins.
- addr_init  out  BitAddr+1  boundary index k; the manager writes (0,k) and (k,0).
- data_init  out  9  boundary value for index k.
- i  out  BitAddr+1  inner row index (the manager adds +1).
- j  out  BitAddr+1  inner column index (the manager adds +1).
- max  out  9  registered cell score driven during insert.
- calc_start  out  1  one-cycle pulse: neighbours ready, max unit may compute.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  high in DONE.

Behaviour:
- Reset (rst=0, async):
  - State goes to IDLE.
  - All outputs are 0: en_*, we, calc_start, busy, done, i, j, addr_init, data_init, max.
- Reset mid-run aborts immediately. No partial write completes after rst falls.
- FSM states: IDLE, INIT, READ, CALC, WRITE, NEXT, DONE. All outputs are registered.
- IDLE:
  - start=1 moves to INIT next cycle with k=0.
- INIT:
  - en_init=1, we=1, addr_init=k, data_init=(-(k*GAP_PEN)) mod 512.
  - One index per cycle, k=0..N, so N+1 cycles.
  - After k=N, goes to READ with i=0, j=0; en_init and we drop.
- READ:
  - en_read=1; i and j are held stable.
  - Stays until ready=1, with no timeout.
  - On ready, goes to CALC.
- CALC:
  - Entry cycle: calc_start pulses for exactly 1 cycle; en_read stays 1 so neighbour outputs remain valid.
  - Waits for calc_done and latches calc_max into max on that edge.
  - calc_done already high in the entry cycle is accepted: CALC lasts 1 cycle.
  - calc_done outside CALC is ignored.
  - Goes to WRITE.
- WRITE:
  - en_read=0, en_ins=1, we=1, for exactly 1 cycle; max, i and j stay stable.
  - Goes to NEXT.
- NEXT:
  - All enables are 0.
  - If j<N-1: j++, go to READ.
  - Else if i<N-1: j=0, i++, go to READ.
  - Else go to DONE.
- DONE:
  - done=1, busy=0; i, j and max hold their last values.
  - start=1 restarts: clears done, goes to INIT with k=0, i=j=0.
- start while busy is ignored. start held high in DONE restarts only once per exit from DONE.
- en_init, en_read and en_ins are mutually exclusive in every cycle.
- Index wrap: i and j never exceed N-1, and no wrap occurs during a run.
- Latency when ready and calc_done respond in the same cycle they are requested:
  - Per cell: READ 1 + CALC 1 + WRITE 1 + NEXT 1 = 4 cycles.
  - Full run: (N+1) + 4*N*N cycles from the first INIT cycle to DONE entry.

Test Plan:
- Reset/idle:
  - rst=0 at t0 → every output 0.
  - Release rst, keep start=0 for 20 cycles → busy=0, done=0, no enable ever high.
- Boundary init (N=5, GAP_PEN=2):
  - Pulse start → 6 consecutive cycles with en_init=we=1.
  - addr_init goes 0..5; data_init goes 0, 510, 508, 506, 504, 502.
- Zero-wait fill:
  - Tie ready=1; return calc_done=1 in the calc_start cycle with calc_max=7+4*i+j.
  - Expect 25 WRITE pulses in row-major order with max matching each cell, and done at cycle 6+100.
- Stalled handshakes:
  - At cell (1,1), hold ready=0 for 5 cycles and delay calc_done by 3 cycles with calc_max=14.
  - Expect i=1, j=1 and en_read=1 stable throughout, a single calc_start pulse, and WRITE max=14.
- Spurious and illegal inputs:
  - calc_done pulses during READ and NEXT → ignored.
  - start pulses mid-fill → ignored; the sequence is unchanged.
- Reset mid-run and restart:
  - Assert rst during the WRITE of (2,3) → en_ins drops asynchronously and the state is IDLE.
  - A new start reruns from INIT k=0.
  - A start in DONE also reruns from INIT k=0 and clears done.
